// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential divider: step count, counter sizing,
// the signed minimum constant and the latched per-division flags.
package divider_seq_pkg;

    // Sign/mode information captured alongside the operands at S = 0.
    typedef struct packed {
        logic u;   // unsigned mode
        logic sx;  // dividend negative (signed mode only)
        logic sy;  // divisor negative (signed mode only)
        logic dz;  // divide by zero
        logic ov;  // MIN / -1 in signed mode
    } div_flags_t;

    // Number of iteration cycles per division.
    function automatic int n_steps(input int width, input int steps);
        return width / steps;
    endfunction

    // Counter has to reach N+1, so it needs states 0..N+1.
    function automatic int cnt_width(input int width, input int steps);
        return $clog2(width / steps + 2);
    endfunction

    // Most negative two's complement value of the given width (zero-extended).
    function automatic logic [63:0] signed_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring division step: shift in one dividend bit, try the subtract,
// keep the difference only when it did not borrow.
module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] r1;
    logic [WIDTH:0] d;

    // Trial subtraction one bit wider than the operands; the top bit is the borrow.
    always_comb begin
        r1     = {rem_i, bit_i};
        d      = r1 - {1'b0, div_i};
        qbit_o = ~d[WIDTH];
        rem_o  = d[WIDTH] ? r1[WIDTH-1:0] : d[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle integer divider with run/stall handshake. Unsigned or signed
// floored division, STEPS quotient bits per cycle, divide-by-zero and
// overflow flags. Results are valid in the single cycle where S = N+1.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             u,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             stall,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dz,
    output logic             ov
);

    localparam int               N      = n_steps(WIDTH, STEPS);
    localparam int               CW     = cnt_width(WIDTH, STEPS);
    localparam logic [CW-1:0]    S_LAST = CW'(N + 1);
    localparam logic [WIDTH-1:0] MIN    = WIDTH'(signed_min(WIDTH));

    logic [CW-1:0]    s_q, s_d;
    logic [WIDTH-1:0] q_q, q_d;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_q, r_d;     // partial remainder
    logic [WIDTH-1:0] ym_q, ym_d;   // divisor magnitude
    div_flags_t       fl_q, fl_d;

    logic [WIDTH-1:0] xm, ymag;
    logic [WIDTH-1:0] r_nx, q_nx;

    // Operand magnitudes; |MIN| comes out as 2^(WIDTH-1) read unsigned.
    always_comb begin
        xm   = x;
        ymag = y;
        if (!u) begin
            if (x[WIDTH-1]) xm   = -x;
            if (y[WIDTH-1]) ymag = -y;
        end
    end

    // STEPS restoring steps chained within one cycle.
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [WIDTH-1:0] r_in, q_in, r_out, q_out;
        logic             qbit;
        if (i == 0) begin : g_first
            assign r_in = r_q;
            assign q_in = q_q;
        end else begin : g_next
            assign r_in = g_step[i-1].r_out;
            assign q_in = g_step[i-1].q_out;
        end
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_i  (r_in),
            .bit_i  (q_in[WIDTH-1]),
            .div_i  (ym_q),
            .rem_o  (r_out),
            .qbit_o (qbit)
        );
        assign q_out = {q_in[WIDTH-2:0], qbit};
    end
    assign r_nx = g_step[STEPS-1].r_out;
    assign q_nx = g_step[STEPS-1].q_out;

    // Step counter: counts while run is high, wraps after N+1, clears when run drops.
    always_comb begin
        s_d = '0;
        if (run && s_q != S_LAST) s_d = s_q + CW'(1);
    end

    // Datapath next state: latch operands at S = 0, iterate during S = 1..N, else hold.
    always_comb begin
        q_d  = q_q;
        r_d  = r_q;
        ym_d = ym_q;
        fl_d = fl_q;
        if (run && s_q == '0) begin
            q_d     = xm;
            r_d     = '0;
            ym_d    = ymag;
            fl_d.u  = u;
            fl_d.sx = ~u & x[WIDTH-1];
            fl_d.sy = ~u & y[WIDTH-1];
            fl_d.dz = (y == '0);
            fl_d.ov = ~u & (x == MIN) & (y == '1);
        end else if (run && s_q != S_LAST) begin
            q_d = q_nx;
            r_d = r_nx;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q  <= '0;
            q_q  <= '0;
            r_q  <= '0;
            ym_q <= '0;
            fl_q <= '0;
        end else begin
            s_q  <= s_d;
            q_q  <= q_d;
            r_q  <= r_d;
            ym_q <= ym_d;
            fl_q <= fl_d;
        end
    end

    assign stall = run & (s_q != S_LAST);

    // Result fix-up. Divide-by-zero leaves all ones in q and |x| in r, so
    // restoring the dividend sign gives rem = x; floored signed division
    // adjusts quotient and remainder when the operand signs differ.
    always_comb begin
        quot = q_q;
        rem  = r_q;
        dz   = 1'b0;
        ov   = 1'b0;
        if (fl_q.u || fl_q.dz) begin
            if (fl_q.sx) rem = -r_q;
        end else if (fl_q.sx == fl_q.sy) begin
            if (fl_q.sy) rem = -r_q;
        end else if (r_q == '0) begin
            quot = -q_q;
        end else begin
            quot = ~q_q;  // -(q0 + 1)
            rem  = fl_q.sy ? (r_q - ym_q) : (ym_q - r_q);
        end
        if (s_q == S_LAST) begin
            dz = fl_q.dz;
            ov = fl_q.ov;
        end
    end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
Parametrised multi-cycle integer divider. Successor to the fixed 32-bit unsigned iterative divider.
Sits beside the processor ALU and uses the same run/stall handshake, so the pipeline freezes while a division is in progress.
Adds signed floored division (Oberon DIV/MOD semantics), configurable width, 1 or 2 quotient bits per cycle, and divide-by-zero and overflow flags.

Parameters:
WIDTH, 32, operand/result width in bits; even, 8..64
STEPS, 1, quotient bits retired per cycle; 1 or 2; WIDTH mod STEPS = 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  division requested; held high with operands stable until stall falls
u    in  1  1 = unsigned, 0 = signed (two's complement)
x    in  WIDTH  dividend
y    in  WIDTH  divisor
stall  out  1  high while the result is not yet valid
quot  out  WIDTH  quotient
rem  out  WIDTH  remainder
dz  out  1  divide by zero (y = 0); valid with results
ov  out  1  signed overflow (x = MIN, y = -1, u = 0); valid with results

Behaviour:
- N = WIDTH/STEPS. Step counter S, range 0..N+1.
- S update: run low -> S = 0 next clock; run high -> S = S+1, except S = N+1 wraps to 0.
- Wrap allows back-to-back divisions with run held high. The second division uses the operands present at its own S = 0.
- stall = run & (S != N+1), combinational. Stall is high for exactly N+1 cycles per division.
- Results and flags are valid in the cycle with S = N+1, run high. They are driven combinationally from registers and sign information latched at S = 0.
- S = 0: latch the operand magnitudes. Unsigned mode: raw values. Signed mode: |x| and |y|, with |MIN| = 2^(WIDTH-1) as an unsigned value. Also latch sx, sy, u, dz, ov. Clear the partial remainder.
- S = 1..N: STEPS restoring steps per cycle, chained combinationally. Each step:
  - r1 = {r, next quotient-register MSB}
  - d = r1 - |y|, computed WIDTH+1 bits wide
  - new bit = ~d[WIDTH]
  - r = d[WIDTH] ? r1 : d
  - the quotient register shifts left by 1, inserting the new bit
- Unsigned result (S = N+1): quot = q0, rem = r0.
- Signed fix-up, floored (rem takes the sign of y, quot = floor(x/y)). Here q0, r0 are the unsigned results:
  - signs equal: quot = q0, rem = sy ? -r0 : r0
  - signs differ, r0 = 0: quot = -q0, rem = 0
  - signs differ, r0 != 0: quot = -(q0+1); rem = sy ? -(|y|-r0) : (|y|-r0)
- Divide by zero, either mode: dz = 1; quot = all ones; rem = x unchanged. The signed fix-up is bypassed.
- Overflow: ov = 1; quot = MIN (wrapped); rem = 0. Ordinary flow produces these values; the flag is informational.
- dz and ov read 0 whenever S != N+1.
- run dropped mid-division: abort. S = 0 next clock, stall low. No other state is significant.
- Operands changed while stall is high: a protocol violation. Results are undefined, but the counter sequence is unaffected.
- rst low, asynchronous: S = 0, all datapath registers and latched flags = 0. Outputs during reset: stall = run; quot = rem = 0; dz = ov = 0. The first division after rst rises begins at S = 0.

Decomposition:
- Shared package holds:
  - step-count constant function N(WIDTH, STEPS)
  - signed MIN constant generator
  - counter width: clog2(N+2)
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated STEPS times in a chain.
- Sign fix-up and the control counter stay in divider_seq.

Test Plan:
- WIDTH=32, STEPS=1, u=1, x=100, y=7, run held -> stall high 33 cycles, then low one cycle; quot=14, rem=2, dz=0, ov=0.
- u=0, x=-7, y=2 -> quot=-4, rem=1. Then x=7, y=-2 -> quot=-4, rem=-1. Then x=-7, y=-2 -> quot=3, rem=-1. Then x=-8, y=2 -> quot=-4, rem=0.
- u=0, x=5, y=0 -> dz=1, quot=FFFFFFFF, rem=5. Then u=0, x=80000000h, y=FFFFFFFFh -> ov=1, quot=80000000h, rem=0.
- run held across two divisions (1000/10, then 1001/10 presented at wrap) -> results 100 r0 and 100 r1, each after 33 stall cycles, with no idle cycle between.
- Abort at S=10 by dropping run, and separately rst pulsed low at S=20 -> stall low and counter 0 immediately/next clock; the following 100/7 completes correctly in 33 cycles.
- STEPS=2, WIDTH=16, random 10k signed and unsigned pairs against a reference model -> all match; stall high 9 cycles each.
